// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter's receiver ports and its merged transmitter.
// Widths are the resolved ones: zero-width sidebands are carried as 1-bit placeholders.
interface axis_if #(
  parameter int DATA_W = 8,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
);
  localparam int KEEP_W = DATA_W / 8;

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tstrb;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              twakeup;

  modport transmitter (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport receiver (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_INPUTS AXI-Stream sources onto one output,
// holding a grant until tlast, with a single full-throughput output register stage.
module axis_rr_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 0,
  parameter int TDEST_WIDTH = 0,
  parameter int TUSER_WIDTH = 0,
  localparam int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_if.receiver             s_axis [NUM_INPUTS],
  axis_if.transmitter          m_axis,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_active
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int ID_W   = (TID_WIDTH   > 0) ? TID_WIDTH   : 1;
  localparam int DEST_W = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1;
  localparam int USER_W = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1;
  localparam int CW     = IDX_WIDTH + 1;
  localparam logic [CW-1:0] N_CW = CW'(NUM_INPUTS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] rr_ptr;

  logic                   in_valid  [NUM_INPUTS];
  logic                   in_ready  [NUM_INPUTS];
  logic [TDATA_WIDTH-1:0] in_data   [NUM_INPUTS];
  logic [KEEP_W-1:0]      in_strb   [NUM_INPUTS];
  logic [KEEP_W-1:0]      in_keep   [NUM_INPUTS];
  logic                   in_last   [NUM_INPUTS];
  logic [ID_W-1:0]        in_id     [NUM_INPUTS];
  logic [DEST_W-1:0]      in_dest   [NUM_INPUTS];
  logic [USER_W-1:0]      in_user   [NUM_INPUTS];
  logic                   in_wakeup [NUM_INPUTS];

  logic                   out_valid;
  logic [TDATA_WIDTH-1:0] out_data;
  logic [KEEP_W-1:0]      out_strb;
  logic [KEEP_W-1:0]      out_keep;
  logic                   out_last;
  logic [ID_W-1:0]        out_id;
  logic [DEST_W-1:0]      out_dest;
  logic [USER_W-1:0]      out_user;
  logic                   out_wakeup;

  logic                 granted;
  logic                 take_ok;
  logic                 hs;
  logic                 req_found;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [CW-1:0]        cand;
  logic [IDX_WIDTH-1:0] next_ptr;

  // Interface arrays can only be indexed by constants, so flatten them here.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    assign in_valid[i]     = s_axis[i].tvalid;
    assign in_data[i]      = s_axis[i].tdata;
    assign in_strb[i]      = s_axis[i].tstrb;
    assign in_keep[i]      = s_axis[i].tkeep;
    assign in_last[i]      = s_axis[i].tlast;
    assign in_id[i]        = s_axis[i].tid;
    assign in_dest[i]      = s_axis[i].tdest;
    assign in_user[i]      = s_axis[i].tuser;
    assign in_wakeup[i]    = s_axis[i].twakeup;
    assign in_ready[i]     = granted && (grant_idx == IDX_WIDTH'(i)) && take_ok;
    assign s_axis[i].tready = in_ready[i];
  end

  assign granted      = (state == ST_GRANTED);
  assign grant_active = granted;
  // Output register may accept a new beat when empty or draining this cycle.
  assign take_ok      = ~out_valid | m_axis.tready;
  assign hs           = granted && in_valid[grant_idx] && take_ok;
  assign next_ptr     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_INPUTS.
  always_comb begin
    req_found = 1'b0;
    req_idx   = rr_ptr;
    cand      = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= N_CW) cand = cand - N_CW;
      if (!req_found && in_valid[cand[IDX_WIDTH-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[IDX_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_found) begin
            grant_idx <= req_idx;
            state     <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (hs && in_last[grant_idx]) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_strb   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_id     <= '0;
      out_dest   <= '0;
      out_user   <= '0;
      out_wakeup <= 1'b0;
    end else if (hs) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant_idx];
      out_strb   <= in_strb[grant_idx];
      out_keep   <= in_keep[grant_idx];
      out_last   <= in_last[grant_idx];
      out_id     <= in_id[grant_idx];
      out_dest   <= in_dest[grant_idx];
      out_user   <= in_user[grant_idx];
      out_wakeup <= in_wakeup[grant_idx];
    end else if (m_axis.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign m_axis.tvalid  = out_valid;
  assign m_axis.tdata   = out_data;
  assign m_axis.tstrb   = out_strb;
  assign m_axis.tkeep   = out_keep;
  assign m_axis.tlast   = out_last;
  assign m_axis.tid     = out_id;
  assign m_axis.tdest   = out_dest;
  assign m_axis.tuser   = out_user;
  assign m_axis.twakeup = out_wakeup;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: scripted packets per source, expected output beats
// queued in predicted arbitration order and compared as the merged stream emits them.
module tb_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef logic [10:0] item_t; // {tuser, tkeep, tlast, tdata}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          s_valid [N];
  logic [7:0]    s_data  [N];
  logic          s_last  [N];
  logic          s_ready [N];
  logic          m_ready;
  logic [IW-1:0] grant_idx;
  logic          grant_active;

  axis_if #(.DATA_W(8)) s_if [N] ();
  axis_if #(.DATA_W(8)) m_if ();

  for (genvar i = 0; i < N; i++) begin : g_src
    assign s_if[i].tvalid  = s_valid[i];
    assign s_if[i].tdata   = s_data[i];
    assign s_if[i].tstrb   = 1'b1;
    assign s_if[i].tkeep   = 1'b1;
    assign s_if[i].tlast   = s_last[i];
    assign s_if[i].tid     = 1'b0;
    assign s_if[i].tdest   = 1'b0;
    assign s_if[i].tuser   = s_data[i][0];
    assign s_if[i].twakeup = 1'b0;
    assign s_ready[i]      = s_if[i].tready;
  end
  assign m_if.tready = m_ready;

  axis_rr_arbiter #(.NUM_INPUTS(N), .TDATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .grant_idx    (grant_idx),
    .grant_active (grant_active)
  );

  item_t exp_q[$];
  int    out_cyc[$];
  int    vectors = 0;
  int    errors  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [7:0] d, input logic l);
    return {d[0], 1'b1, l, d};
  endfunction

  // Output monitor: every accepted m_axis beat pops one predicted beat.
  always @(negedge clk) begin
    item_t got;
    item_t e;
    if (rst === 1'b0 && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      got = {m_if.tuser, m_if.tkeep, m_if.tlast, m_if.tdata};
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $error("FAIL unexpected_beat observed=%h expected=none", got);
      end else begin
        e = exp_q.pop_front();
        check("out_beat", 32'(got), 32'(e));
      end
    end
  end

  task automatic wait_ready(input int src);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (s_ready[src] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      vectors++;
      errors++;
      $error("FAIL ready_timeout src=%0d observed=0 expected=1", src);
    end
    @(posedge clk);
    #1;
  endtask

  // Sends one packet; gap_at >= 0 drops tvalid for 3 cycles after that beat.
  task automatic send_pkt(input int src, input int n, input logic [7:0] base, input int gap_at);
    for (int b = 0; b < n; b++) begin
      s_valid[src] = 1'b1;
      s_data[src]  = base + 8'(b);
      s_last[src]  = (b == n - 1);
      wait_ready(src);
      if (b == gap_at) begin
        s_valid[src] = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("gap_grant_idx", 32'(grant_idx), 32'(src));
          check("gap_grant_active", 32'(grant_active), 32'd1);
          for (int j = 0; j < N; j++)
            if (j != src) check("gap_other_ready", 32'(s_ready[j]), 32'd0);
          @(posedge clk);
          #1;
        end
      end
    end
    s_valid[src] = 1'b0;
    s_last[src]  = 1'b0;
  endtask

  task automatic wait_drain;
    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int rise;
    rst     = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = 8'h00;
      s_last[i]  = 1'b0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    for (int i = 0; i < N; i++) check("rst_s_tready", 32'(s_ready[i]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round-robin: all inputs request, order 0,1,2,3,0 with one bubble between packets
    out_cyc.delete();
    exp_q.push_back(mk(8'h00, 1'b0)); exp_q.push_back(mk(8'h01, 1'b1));
    exp_q.push_back(mk(8'h10, 1'b0)); exp_q.push_back(mk(8'h11, 1'b1));
    exp_q.push_back(mk(8'h20, 1'b0)); exp_q.push_back(mk(8'h21, 1'b1));
    exp_q.push_back(mk(8'h30, 1'b0)); exp_q.push_back(mk(8'h31, 1'b1));
    exp_q.push_back(mk(8'h02, 1'b0)); exp_q.push_back(mk(8'h03, 1'b1));
    fork
      begin
        send_pkt(0, 2, 8'h00, -1);
        send_pkt(0, 2, 8'h02, -1);
      end
      send_pkt(1, 2, 8'h10, -1);
      send_pkt(2, 2, 8'h20, -1);
      send_pkt(3, 2, 8'h30, -1);
    join
    wait_drain();
    check("rr_beat_count", 32'(out_cyc.size()), 32'd10);
    if (out_cyc.size() == 10)
      for (int i = 0; i < 9; i++)
        check("rr_beat_spacing", 32'(out_cyc[i+1] - out_cyc[i]), (i % 2 == 1) ? 32'd2 : 32'd1);

    // Single source on input 2: output starts 2 cycles after tvalid rises
    out_cyc.delete();
    exp_q.push_back(mk(8'hA1, 1'b0));
    exp_q.push_back(mk(8'hA2, 1'b0));
    exp_q.push_back(mk(8'hA3, 1'b1));
    rise = cyc;
    send_pkt(2, 3, 8'hA1, -1);
    wait_drain();
    check("single_beat_count", 32'(out_cyc.size()), 32'd3);
    if (out_cyc.size() == 3) begin
      check("single_first_cycle", 32'(out_cyc[0]), 32'(rise + 2));
      check("single_last_cycle", 32'(out_cyc[2]), 32'(rise + 4));
    end
    check("single_grant_idx", 32'(grant_idx), 32'd2);
    check("single_idle_after", 32'(grant_active), 32'd0);

    // Wrap-around: rr_ptr is 3, inputs 1 and 0 request; 0 wins first
    exp_q.push_back(mk(8'h40, 1'b1));
    exp_q.push_back(mk(8'h50, 1'b1));
    fork
      send_pkt(1, 1, 8'h50, -1);
      send_pkt(0, 1, 8'h40, -1);
    join
    wait_drain();
    check("wrap_grant_idx", 32'(grant_idx), 32'd1);

    // Back-pressure: output stalled 5 cycles after beat 1 of a packet from input 1
    m_ready = 1'b0;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(8'h60 + 8'(b), b == 3));
    fork
      send_pkt(1, 4, 8'h60, -1);
      begin
        for (int w = 0; w < 50; w++) begin
          @(negedge clk);
          if (m_if.tvalid === 1'b1) break;
        end
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          check("bp_m_tvalid", 32'(m_if.tvalid), 32'd1);
          check("bp_m_tdata", 32'(m_if.tdata), 32'h60);
          check("bp_s1_tready", 32'(s_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();

    // Mid-packet gap: input 0 pauses, input 1 waits for the packet to finish
    exp_q.push_back(mk(8'h70, 1'b0));
    exp_q.push_back(mk(8'h71, 1'b0));
    exp_q.push_back(mk(8'h72, 1'b1));
    exp_q.push_back(mk(8'h80, 1'b1));
    fork
      send_pkt(0, 3, 8'h70, 0);
      begin
        @(posedge clk);
        #1;
        send_pkt(1, 1, 8'h80, -1);
      end
    join
    wait_drain();

    // Reset during beat 2 of a packet from input 0
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h90;
    s_last[0]  = 1'b0;
    wait_ready(0);
    s_data[0] = 8'h91;
    #1;
    rst = 1'b1;
    #1;
    check("midrst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("midrst_grant_active", 32'(grant_active), 32'd0);
    for (int i = 0; i < N; i++) check("midrst_s_tready", 32'(s_ready[i]), 32'd0);
    s_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(mk(8'hB0, 1'b1));
    exp_q.push_back(mk(8'hC0, 1'b1));
    fork
      send_pkt(3, 1, 8'hC0, -1);
      send_pkt(0, 1, 8'hB0, -1);
    join
    wait_drain();
    check("postrst_grant_idx", 32'(grant_idx), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
